result_collector: RTL

Downstream stage of the multicore Taylor-network array. It captures every valid result pulse from the N parallel `rede_taylor` cores without loss, including pulses from several cores in the same cycle. It arbitrates those results round-robin into a result FIFO and presents them as a single valid/ready stream tagged with the source core index. This replaces the first-match priority mux, which drops results when cores finish together.

---
 rtl/multicore_pkg.sv | 15 +
 rtl/result_collector_if.sv | 13 +
 rtl/result_fifo.sv | 54 +++++
 rtl/result_collector.sv | 113 +++++++++++
 4 files changed

// File: rtl/multicore_pkg.sv
// Shared constants and result word type for the multicore Taylor-network array.
package multicore_pkg;

    localparam int N_CORES = 21;
    localparam int DATA_W  = 28;
    localparam int IDX_W   = 5;

    localparam logic [3:0] OUT_EN_VALID = 4'd1;

    typedef struct packed {
        logic [IDX_W-1:0]         core;
        logic signed [DATA_W-1:0] data;
    } result_t;

endpackage

// File: rtl/result_collector_if.sv
// Collected-result output stream: tagged result word with valid/ready handshake.
interface result_collector_if;
    import multicore_pkg::*;

    logic signed [DATA_W-1:0] m_data;
    logic [IDX_W-1:0]         m_core;
    logic                     m_valid;
    logic                     m_ready;

    modport master (output m_data, output m_core, output m_valid, input m_ready);
    modport slave  (input m_data, input m_core, input m_valid, output m_ready);

endinterface

// File: rtl/result_fifo.sv
// Synchronous FIFO of result_t; head word read combinationally from registered pointers.
module result_fifo
    import multicore_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  result_t        push_dat,
    input  logic           pop,
    output result_t        pop_dat,
    output logic           full,
    output logic           empty,
    output logic [PTR_W:0] count
);

    result_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    // Masked while empty so the head reads as zero after reset.
    assign pop_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + (PTR_W+1)'(1);
            end else if (pop && !push) begin
                count <= count - (PTR_W+1)'(1);
            end
        end
    end

endmodule

// File: rtl/result_collector.sv
// Captures per-core result pulses into hold registers and round-robins them into a tagged result FIFO.
module result_collector
    import multicore_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_CORES*DATA_W-1:0]    io_out,
    input  logic [N_CORES*4-1:0]         out_en,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic [N_CORES-1:0]           overflow,
    input  logic                         ovf_clr,
    result_collector_if.master           m
);

    logic [N_CORES-1:0]       pulse;
    logic [N_CORES-1:0]       hold_v;
    logic [N_CORES-1:0]       grant_oh;
    logic signed [DATA_W-1:0] hold_data [N_CORES];
    logic [IDX_W-1:0]         last_grant;
    logic [IDX_W-1:0]         gnt_idx;
    logic [IDX_W:0]           cand;
    logic                     gnt_v;
    logic                     can_write;
    logic                     pop;
    logic                     full;
    logic                     empty;
    result_t                  push_dat;
    result_t                  head;

    always_comb begin
        pulse = '0;
        for (int k = 0; k < N_CORES; k++) begin
            pulse[k] = (out_en[k*4 +: 4] == OUT_EN_VALID);
        end
    end

    assign pop       = !empty && m.m_ready;
    assign can_write = !full || pop;

    // Search starts one past the last winner and wraps at N_CORES-1.
    always_comb begin
        gnt_v    = 1'b0;
        gnt_idx  = '0;
        cand     = '0;
        grant_oh = '0;
        for (int i = 1; i <= N_CORES; i++) begin
            cand = {1'b0, last_grant} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(N_CORES)) begin
                cand = cand - (IDX_W+1)'(N_CORES);
            end
            if (!gnt_v && hold_v[cand[IDX_W-1:0]]) begin
                gnt_v   = 1'b1;
                gnt_idx = cand[IDX_W-1:0];
            end
        end
        if (!can_write) begin
            gnt_v = 1'b0;
        end
        if (gnt_v) begin
            grant_oh[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        push_dat      = '0;
        push_dat.core = gnt_idx;
        push_dat.data = hold_data[gnt_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_v     <= '0;
            overflow   <= '0;
            last_grant <= IDX_W'(N_CORES - 1);
            for (int k = 0; k < N_CORES; k++) begin
                hold_data[k] <= '0;
            end
        end else begin
            if (gnt_v) begin
                last_grant <= gnt_idx;
            end
            // A set in the same cycle as the clear wins.
            overflow <= (ovf_clr ? '0 : overflow) | (pulse & hold_v & ~grant_oh);
            for (int k = 0; k < N_CORES; k++) begin
                if (pulse[k] && (!hold_v[k] || grant_oh[k])) begin
                    hold_data[k] <= io_out[k*DATA_W +: DATA_W];
                    hold_v[k]    <= 1'b1;
                end else if (grant_oh[k]) begin
                    hold_v[k] <= 1'b0;
                end
            end
        end
    end

    result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (gnt_v),
        .push_dat (push_dat),
        .pop      (pop),
        .pop_dat  (head),
        .full     (full),
        .empty    (empty),
        .count    (fifo_count)
    );

    assign m.m_valid = !empty;
    assign m.m_data  = head.data;
    assign m.m_core  = head.core;

endmodule
